// File: rtl/shot_fire_controller_pkg.sv
// Shared definitions for the shot fire controller and the shot sprite drawer.
package shot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRE,
        ST_FLIGHT,
        ST_CLEAR
    } shot_state_t;

    localparam int SCREEN_W        = 640;
    localparam int SHOT_W          = 8;
    localparam int SHOT_Y0         = 424;
    localparam int SHOT_ROW_CYCLES = 60000;
    localparam int POS_W           = 10;

    // Bits needed to hold a counter that runs 0..n-1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shot_fire_controller_if.sv
// Controller-to-drawer bus plus the collision/round event inputs.
interface shot_fire_controller_if;
    import shot_pkg::*;

    logic             fire;
    logic             shot_clear;
    logic [POS_W-1:0] pos_x;
    logic [1:0]       ammo;
    logic             busy;
    logic             empty;
    logic             hit;
    logic             round_start;

    modport master (
        output fire, shot_clear, pos_x, ammo, busy, empty,
        input  hit, round_start
    );

    modport slave (
        input  fire, shot_clear, pos_x, ammo, busy, empty,
        output hit, round_start
    );

endinterface

// File: rtl/shot_fire_controller_debouncer.sv
// Two-flop synchronizer and debounce counter for one raw button, with a rise pulse.
module button_debouncer
    import shot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
            rise   <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync_2;
                rise  <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/shot_fire_controller.sv
// Shot lifecycle controller: button conditioning, ammo tracking, aim and fire/clear sequencing.
//   state     | meaning
//   ST_IDLE   | no shot out, waiting for an accepted trigger
//   ST_FIRE   | fire pulse to the drawer, flight timer cleared
//   ST_FLIGHT | shot travelling, ends on hit or timeout
//   ST_CLEAR  | one-cycle clear to the drawer (also the reset state)
module shot_fire_controller
    import shot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MOVE_DIV        = 100000,
    parameter int FLIGHT_CYCLES   = 26160000,
    parameter int AMMO_MAX        = 3,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = SCREEN_W - SHOT_W,
    parameter int X_INIT          = 316
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   btn_fire,
    input  logic                   btn_left,
    input  logic                   btn_right,
    shot_fire_controller_if.master bus
);

    localparam int MW = cnt_width(MOVE_DIV);
    localparam int FW = cnt_width(FLIGHT_CYCLES);

    shot_state_t   state;
    logic [FW-1:0] flight_cnt;
    logic [MW-1:0] move_cnt;
    logic          fire_req;
    logic          lvl_fire;
    logic          lvl_left;
    logic          lvl_right;
    logic          unused_left_rise;
    logic          unused_right_rise;
    logic          one_dir;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fire (
        .clk(clk), .reset(reset), .btn(btn_fire), .level(lvl_fire), .rise(fire_req)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk(clk), .reset(reset), .btn(btn_left), .level(lvl_left), .rise(unused_left_rise)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk(clk), .reset(reset), .btn(btn_right), .level(lvl_right), .rise(unused_right_rise)
    );

    assign bus.busy  = (state != ST_IDLE);
    assign bus.empty = (bus.ammo == 2'd0);

    // round_start refills last so it wins over nothing else here: a same-cycle trigger is already blocked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_CLEAR;
            bus.fire       <= 1'b0;
            bus.shot_clear <= 1'b1;
            bus.ammo       <= 2'(AMMO_MAX);
            flight_cnt     <= '0;
        end else begin
            bus.fire       <= 1'b0;
            bus.shot_clear <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fire_req && (bus.ammo != 2'd0) && !bus.round_start) begin
                        state    <= ST_FIRE;
                        bus.fire <= 1'b1;
                        bus.ammo <= bus.ammo - 2'd1;
                    end
                end
                ST_FIRE: begin
                    flight_cnt <= '0;
                    state      <= ST_FLIGHT;
                end
                ST_FLIGHT: begin
                    if (bus.hit || (flight_cnt == FW'(FLIGHT_CYCLES - 1))) begin
                        state          <= ST_CLEAR;
                        bus.shot_clear <= 1'b1;
                    end else begin
                        flight_cnt <= flight_cnt + FW'(1);
                    end
                end
                ST_CLEAR: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
            if (bus.round_start) begin
                bus.ammo <= 2'(AMMO_MAX);
            end
        end
    end

    assign one_dir = lvl_left ^ lvl_right;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            move_cnt  <= '0;
            bus.pos_x <= POS_W'(X_INIT);
        end else if (!one_dir) begin
            move_cnt <= '0;
        end else if (move_cnt == MW'(MOVE_DIV - 1)) begin
            move_cnt <= '0;
            if (lvl_right && (bus.pos_x < POS_W'(X_MAX))) begin
                bus.pos_x <= bus.pos_x + POS_W'(1);
            end else if (lvl_left && (bus.pos_x > POS_W'(X_MIN))) begin
                bus.pos_x <= bus.pos_x - POS_W'(1);
            end
        end else begin
            move_cnt <= move_cnt + MW'(1);
        end
    end

endmodule

// File: tb/tb_shot_fire_controller.sv
// Scoreboard bench for shot_fire_controller with small timing parameters.
module tb_shot_fire_controller;

    typedef struct {
        int kind;   // 0 = fire pulse, 1 = shot_clear pulse
        bit rel;    // window relative to the last observed fire pulse
        int lo;
        int hi;
        int ammo;   // -1 = don't care
    } exp_t;

    logic clk;
    logic reset;
    logic btn_fire;
    logic btn_left;
    logic btn_right;
    int   cyc = 0;
    int   last_fire = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   mon_en = 0;
    exp_t sb_q[$];

    shot_fire_controller_if bus ();

    shot_fire_controller #(
        .DEBOUNCE_CYCLES(4),
        .MOVE_DIV(2),
        .FLIGHT_CYCLES(20),
        .AMMO_MAX(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_fire(btn_fire),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int kind, input bit rel, input int lo, input int hi, input int ammo);
        exp_t e;
        e.kind = kind; e.rel = rel; e.lo = lo; e.hi = hi; e.ammo = ammo;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic sb_check(input int kind, input string nm);
        exp_t e;
        int lo;
        int hi;
        n_checks++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s: unexpected pulse at cycle %0d, nothing pending", nm, cyc);
        end else begin
            e  = sb_q.pop_front();
            lo = e.rel ? last_fire + e.lo : e.lo;
            hi = e.rel ? last_fire + e.hi : e.hi;
            if (e.kind != kind || cyc < lo || cyc > hi || (e.ammo >= 0 && int'(bus.ammo) != e.ammo))
                $display("FAIL %s: got kind %0d at cycle %0d ammo %0d, expected kind %0d in %0d..%0d ammo %0d",
                         nm, kind, cyc, bus.ammo, e.kind, lo, hi, e.ammo);
            else
                n_pass++;
        end
        if (kind == 0) last_fire = cyc;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.fire) sb_check(0, "fire_event");
            if (bus.shot_clear) sb_check(1, "clear_event");
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int t0;
        int t1;
        reset = 1'b1;
        btn_fire = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        bus.hit = 1'b0; bus.round_start = 1'b0;
        #1 reset = 1'b0;
        #2;
        chk("rst_fire", bus.fire, 0);
        chk("rst_clear", bus.shot_clear, 1);
        chk("rst_pos_x", int'(bus.pos_x), 316);
        chk("rst_ammo", bus.ammo, 3);
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1);
        chk("rst_empty", bus.empty, 0);
        chk("rst_clear_held", bus.shot_clear, 1);
        #2 reset = 1'b1;
        #1 chk("clear_after_release", bus.shot_clear, 1);
        @(negedge clk);
        chk("clear_drop", bus.shot_clear, 0);
        chk("idle_after_reset", bus.busy, 0);
        chk("no_fire_after_reset", bus.fire, 0);
        mon_en = 1;

        // 2-cycle glitch must not be accepted
        repeat (2) @(negedge clk);
        btn_fire = 1'b1;
        repeat (2) @(negedge clk);
        btn_fire = 1'b0;
        repeat (15) @(negedge clk);
        chk("glitch_ammo", bus.ammo, 3);

        // clean press, flight times out
        t0 = cyc;
        push(0, 0, t0 + 6, t0 + 8, 2);
        push(1, 1, 21, 21, -1);
        btn_fire = 1'b1;
        wait_until(t0 + 10);
        btn_fire = 1'b0;
        wait_until(t0 + 40);
        chk("shot1_ammo", bus.ammo, 2);
        chk("shot1_idle", bus.busy, 0);

        // second press during flight is dropped
        t0 = cyc;
        push(0, 0, t0 + 6, t0 + 8, 1);
        push(1, 1, 21, 21, -1);
        btn_fire = 1'b1;
        wait_until(t0 + 6);
        btn_fire = 1'b0;
        wait_until(t0 + 14);
        btn_fire = 1'b1;
        wait_until(t0 + 22);
        btn_fire = 1'b0;
        wait_until(t0 + 25);
        chk("flight_drop_ammo", bus.ammo, 1);
        chk("flight_busy", bus.busy, 1);
        wait_until(t0 + 45);
        chk("flight_drop_idle", bus.busy, 0);

        // hit ends the flight; a later stray hit in IDLE is ignored
        t0 = cyc;
        push(0, 0, t0 + 6, t0 + 8, 0);
        push(1, 0, t0 + 13, t0 + 13, -1);
        btn_fire = 1'b1;
        wait_until(t0 + 8);
        btn_fire = 1'b0;
        wait_until(t0 + 12);
        bus.hit = 1'b1;
        @(negedge clk);
        bus.hit = 1'b0;
        wait_until(t0 + 25);
        bus.hit = 1'b1;
        @(negedge clk);
        bus.hit = 1'b0;
        wait_until(t0 + 35);
        chk("hit_ammo", bus.ammo, 0);
        chk("hit_empty", bus.empty, 1);

        // fourth press with no ammo
        t0 = cyc;
        btn_fire = 1'b1;
        wait_until(t0 + 10);
        btn_fire = 1'b0;
        wait_until(t0 + 30);
        chk("empty_ammo", bus.ammo, 0);
        chk("empty_flag", bus.empty, 1);
        chk("empty_idle", bus.busy, 0);

        // refill
        bus.round_start = 1'b1;
        @(negedge clk);
        bus.round_start = 1'b0;
        chk("refill_ammo", bus.ammo, 3);
        chk("refill_empty", bus.empty, 0);

        // round_start in the same cycle as fire_req drops the trigger
        t0 = cyc;
        btn_fire = 1'b1;
        wait_until(t0 + 6);
        bus.round_start = 1'b1;
        wait_until(t0 + 7);
        bus.round_start = 1'b0;
        wait_until(t0 + 10);
        btn_fire = 1'b0;
        wait_until(t0 + 30);
        chk("coincide_ammo", bus.ammo, 3);
        chk("coincide_idle", bus.busy, 0);

        t0 = cyc;
        push(0, 0, t0 + 6, t0 + 8, 2);
        push(1, 1, 21, 21, -1);
        btn_fire = 1'b1;
        wait_until(t0 + 10);
        btn_fire = 1'b0;
        wait_until(t0 + 40);
        chk("refire_ammo", bus.ammo, 2);

        // aim right, both held, then saturate at 632
        t0 = cyc;
        btn_right = 1'b1;
        wait_until(t0 + 20);
        chk("right_step_a", int'(bus.pos_x), 323);
        wait_until(t0 + 21);
        chk("right_step_b", int'(bus.pos_x), 323);
        wait_until(t0 + 22);
        chk("right_step_c", int'(bus.pos_x), 324);
        btn_left = 1'b1;
        wait_until(t0 + 40);
        chk("both_frozen_a", int'(bus.pos_x), 327);
        wait_until(t0 + 44);
        chk("both_frozen_b", int'(bus.pos_x), 327);
        btn_left = 1'b0;
        wait_until(t0 + 60);
        chk("right_resume", int'(bus.pos_x), 332);
        wait_until(t0 + 659);
        chk("right_near_max", int'(bus.pos_x), 631);
        wait_until(t0 + 660);
        chk("right_at_max", int'(bus.pos_x), 632);
        wait_until(t0 + 700);
        chk("right_saturated", int'(bus.pos_x), 632);
        btn_right = 1'b0;
        wait_until(t0 + 720);
        chk("released_hold", int'(bus.pos_x), 632);

        // aim left down to 0
        t1 = cyc;
        btn_left = 1'b1;
        wait_until(t1 + 10);
        chk("left_step", int'(bus.pos_x), 630);
        wait_until(t1 + 1269);
        chk("left_near_min", int'(bus.pos_x), 1);
        wait_until(t1 + 1270);
        chk("left_at_min", int'(bus.pos_x), 0);
        wait_until(t1 + 1320);
        chk("left_saturated", int'(bus.pos_x), 0);
        btn_left = 1'b0;

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
